seven_seg_scanner: RTL and testbench

Time-multiplexed driver for a common-anode seven-segment display bank. It accepts NUM_DIGITS packed hex nibbles with per-digit blank and decimal-point controls. A prescaled scan counter walks the digits, with a dead-time guard between slots to prevent ghosting. It drives active-low anode, segment and dp pins directly from registers. It is the clocked, width-generalised successor to the combinational hex decoder and sits between the ALU result/opcode registers and the board display pins.

---
 rtl/seven_seg_scanner.sv | 137 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with dead-time blanking.
// Optional leading-zero suppression via `define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segs,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] font(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            segs_q, segs_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0] sup;
    logic [3:0]            nib;
    logic                  dark;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // A digit is suppressed while it and everything above it is a bare zero.
    logic zero_run;
    always_comb begin
        sup      = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (digits[4*i +: 4] == 4'h0) && !dp[i];
            sup[i]   = zero_run;
        end
    end
`else
    assign sup = '0;
`endif

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        frame_tick_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    pend_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Tick lands on the output cycle showing digit 0's first blank cycle.
            if (pend_q && cnt_q == '0) begin
                frame_tick_d = 1'b1;
                pend_d       = 1'b0;
            end
        end

        nib  = digits[4*idx_q +: 4];
        dark = !en || (cnt_q < CNT_BLANK) || blank_mask[idx_q] || sup[idx_q];

        anode_d = '1;
        segs_d  = 7'h7F;
        dp_n_d  = 1'b1;
        if (!dark) begin
            anode_d[idx_q] = 1'b0;
            segs_d         = font(nib);
            dp_n_d         = ~dp[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            anode_q      <= '1;
            segs_q       <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            anode_q      <= anode_d;
            segs_q       <= segs_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign segs       = segs_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic [3:0]  dp;
    logic [3:0]  anode;
    logic [6:0]  segs;
    logic        dp_n;
    logic        frame_tick;

    int          total = 0;
    int          bad   = 0;
    logic [12:0] exp_q[$];
    string       name_q[$];
    string       phase;
    logic [12:0] mon_e;
    string       mon_n;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits    (digits),
        .blank_mask(blank_mask),
        .dp        (dp),
        .anode     (anode),
        .segs      (segs),
        .dp_n      (dp_n),
        .frame_tick(frame_tick)
    );

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got anode=%h segs=%h dp_n=%b tick=%b, expected anode=%h segs=%h dp_n=%b tick=%b",
                     nm, act[12:9], act[8:2], act[1], act[0], e[12:9], e[8:2], e[1], e[0]);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            check(mon_n, {anode, segs, dp_n, frame_tick}, mon_e);
        end
    end

    task automatic push(input logic [3:0] an, input logic [6:0] sg, input logic dpn, input logic ft);
        exp_q.push_back({an, sg, dpn, ft});
        name_q.push_back(phase);
    endtask

    // One slot: a single blank cycle followed by three drive cycles.
    task automatic push_slot(input logic [3:0] an, input logic [6:0] sg, input logic dpn, input logic ft);
        push(4'hF, 7'h7F, 1'b1, ft);
        repeat (3) push(an, sg, dpn, 1'b0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        digits     = 16'h0000;
        blank_mask = 4'b0000;
        dp         = 4'b0000;
        phase      = "reset";
        wait_cyc(3);
        check("reset_state", {anode, segs, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        rst_n = 1'b1;

        phase = "first_frame";
        push_slot(4'hE, 7'h40, 1'b1, 1'b0);
        push_slot(4'hD, 7'h40, 1'b1, 1'b0);
        push_slot(4'hB, 7'h40, 1'b1, 1'b0);
        push_slot(4'h7, 7'h40, 1'b1, 1'b0);
        wait_cyc(16);

        phase  = "font_sweep";
        digits = 16'h89AF;
        push_slot(4'hE, 7'h0E, 1'b1, 1'b1);
        push_slot(4'hD, 7'h08, 1'b1, 1'b0);
        push_slot(4'hB, 7'h10, 1'b1, 1'b0);
        push_slot(4'h7, 7'h00, 1'b1, 1'b0);
        wait_cyc(16);

        phase      = "mask_dp";
        digits     = 16'h1234;
        blank_mask = 4'b0100;
        dp         = 4'b0001;
        push_slot(4'hE, 7'h19, 1'b0, 1'b1);
        push_slot(4'hD, 7'h30, 1'b1, 1'b0);
        push_slot(4'hF, 7'h7F, 1'b1, 1'b0);
        push_slot(4'h7, 7'h79, 1'b1, 1'b0);
        wait_cyc(16);

        phase      = "leading_zero";
        digits     = 16'h0050;
        blank_mask = 4'b0000;
        dp         = 4'b0000;
        push_slot(4'hE, 7'h40, 1'b1, 1'b1);
        push_slot(4'hD, 7'h12, 1'b1, 1'b0);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        push_slot(4'hF, 7'h7F, 1'b1, 1'b0);
        push_slot(4'hF, 7'h7F, 1'b1, 1'b0);
`else
        push_slot(4'hB, 7'h40, 1'b1, 1'b0);
        push_slot(4'h7, 7'h40, 1'b1, 1'b0);
`endif
        wait_cyc(16);

        phase  = "freeze_pre";
        digits = 16'h4321;
        push_slot(4'hE, 7'h79, 1'b1, 1'b1);
        push_slot(4'hD, 7'h24, 1'b1, 1'b0);
        push(4'hF, 7'h7F, 1'b1, 1'b0);
        push(4'hB, 7'h30, 1'b1, 1'b0);
        wait_cyc(10);

        phase = "freeze_dark";
        en    = 1'b0;
        repeat (10) push(4'hF, 7'h7F, 1'b1, 1'b0);
        wait_cyc(10);

        phase = "freeze_resume";
        en    = 1'b1;
        repeat (2) push(4'hB, 7'h30, 1'b1, 1'b0);
        push_slot(4'h7, 7'h19, 1'b1, 1'b0);
        push(4'hF, 7'h7F, 1'b1, 1'b1);
        push(4'hE, 7'h79, 1'b1, 1'b0);
        wait_cyc(8);

        #1 rst_n = 1'b0;
        #1 check("async_reset", {anode, segs, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        check("reset_hold", {anode, segs, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
        rst_n = 1'b1;
        phase = "after_reset";
        push_slot(4'hE, 7'h79, 1'b1, 1'b0);
        wait_cyc(4);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
